spi_dac_rx: RTL and testbench

SPI mode-0 receiver (peripheral end) for the 8-bit DAC link driven by our SPI DAC transmitter. It samples MOSI on SCLK rising edges while CS_n is low. The serial pins are asynchronous to clk, so they are synchronized first. A frame is committed to a valid/ready output register when CS_n rises. The block is used as the loopback/verification endpoint on the board and as the front end of the DAC model.

---
 rtl/spi_rx_pkg.sv | 20 ++
 rtl/spi_sync.sv | 35 +++
 rtl/spi_dac_rx.sv | 152 +++++++++++++++
 tb/tb_spi_dac_rx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the SPI DAC receiver.
// Holds the FSM state encoding, default frame/synchronizer sizes and the
// helper that sizes the bit counter so it can hold the value DATA_W.
package spi_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } state_e;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_SYNC_STAGES = 2;

  // Counter must reach DATA_W itself, hence the +1.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Purpose: multi-flop synchronizer for one asynchronous pin, with edge detect.
// Latency: STAGES clk cycles to sync_o; rise_o/fall_o valid in the same cycle.
// Backpressure: none (free-running).
// Ports: clk, reset (async, active-high), async_i (raw pin),
//        sync_o (synchronized level), rise_o / fall_o (one-cycle edge pulses).
module spi_sync #(
  parameter int   STAGES  = 2,     // at least 2
  parameter logic RST_VAL = 1'b0   // idle level of the pin
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_q;
  logic              hist_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_q <= {STAGES{RST_VAL}};
      hist_q  <= RST_VAL;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], async_i};
      hist_q  <= chain_q[STAGES-1];
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign rise_o = chain_q[STAGES-1] & ~hist_q;
  assign fall_o = ~chain_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_dac_rx.sv
// Purpose: SPI mode-0 peripheral receiver; one DATA_W-bit frame per CS_n window.
// Latency: frame lands in rx_data/rx_valid SYNC_STAGES+2 clk after the CS_n pin rises.
// Backpressure: rx_valid/rx_ready; a frame closing while rx_valid is still pending is dropped (overrun pulse).
// Ports: clk, reset (async, active-high), spi_sclk/spi_mosi/spi_cs_n (async pins),
//        rx_ready (consumer), rx_data/rx_valid (output register), busy (FSM not idle),
//        frame_err (bad bit count pulse), overrun (dropped frame pulse).
module spi_dac_rx
  import spi_rx_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_cs_n,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CNT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  // Synchronized pins and edges
  logic sclk_rise, sclk_fall_unused, sclk_level_unused;
  logic cs_rise, cs_fall, cs_level_unused;
  logic s_mosi, mosi_rise_unused, mosi_fall_unused;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .async_i(spi_sclk),
    .sync_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall_unused)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .async_i(spi_cs_n),
    .sync_o(cs_level_unused), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .async_i(spi_mosi),
    .sync_o(s_mosi), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  // State
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                extra_q, extra_d;
  logic                commit_q, commit_d;   // frame closed cleanly, commit next cycle
  logic                err_q, err_d;         // frame closed badly, flag next cycle
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      extra_q     <= 1'b0;
      commit_q    <= 1'b0;
      err_q       <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      extra_q     <= extra_d;
      commit_q    <= commit_d;
      err_q       <= err_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    extra_d   = extra_q;
    commit_d  = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = ACTIVE;
          bit_cnt_d = '0;
          shift_d   = '0;
          extra_d   = 1'b0;
        end
      end
      ACTIVE: begin
        // CS_n closing wins over a coincident SCLK edge.
        if (cs_rise) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (sclk_rise) begin
          shift_d   = {shift_q[DATA_W-2:0], s_mosi};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) state_d = FULL;
        end
      end
      FULL: begin
        if (cs_rise) begin
          state_d = IDLE;
          if (extra_q) err_d = 1'b1;
          else         commit_d = 1'b1;
        end else if (sclk_rise) begin
          extra_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Output register stage; commit and error are mutually exclusive, so
    // frame_err and overrun can never pulse together.
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = err_q;
    overrun_d   = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (commit_q) begin
      if (rx_valid_q && !rx_ready) begin
        overrun_d = 1'b1;
      end else begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign busy      = (state_q != IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_spi_dac_rx.sv
module tb_spi_dac_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_sclk, spi_mosi, spi_cs_n, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, busy, frame_err, overrun;

  int errors = 0;
  int checks = 0;

  // Monitor state
  logic [7:0] acc_q[$];
  int fe_cnt = 0;
  int ov_cnt = 0;
  int both_cnt = 0;
  int vcyc = 0;

  always #5 clk = ~clk;

  spi_dac_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .rx_ready(rx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && rx_ready) acc_q.push_back(rx_data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_err && overrun) both_cnt++;
      if (rx_valid) vcyc++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n, input int half);
    spi_cs_n = 1'b0;
    wait_clk(half);
    for (int i = 0; i < n; i++) begin
      spi_mosi = bits[n-1-i];
      wait_clk(half);
      spi_sclk = 1'b1;
      wait_clk(half);
      spi_sclk = 1'b0;
    end
    wait_clk(half);
  endtask

  task automatic close_cs();
    @(posedge clk);
    #1;
    spi_cs_n = 1'b1;
  endtask

  task automatic send_frame(input logic [15:0] bits, input int n, input int half);
    send_bits(bits, n, half);
    close_cs();
    wait_clk(20);
  endtask

  task automatic test_reset();
    reset = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1; rx_ready = 1'b1;
    #3;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_pulses got fe=%b ov=%b exp 0 0", frame_err, overrun); end
    wait_clk(4);
    reset = 1'b0;
    wait_clk(10);
    checks++; if (busy !== 1'b0 || rx_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle got busy=%b vld=%b exp 0 0", busy, rx_valid); end
  endtask

  task automatic test_single();
    int fe0, ov0, v0, lat;
    acc_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt; v0 = vcyc;
    rx_ready = 1'b1;
    send_bits(16'h00A5, 8, 50);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    close_cs();
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      wait_clk(1);
      if (rx_valid) begin lat = i; break; end
    end
    checks++; if (lat != 4) begin errors++; $display("FAIL single_latency got=%0d exp=4", lat); end
    wait_clk(20);
    checks++; if (acc_q.size() != 1) begin errors++; $display("FAIL single_count got=%0d exp=1", acc_q.size()); end
    else begin
      checks++; if (acc_q[0] !== 8'hA5) begin errors++; $display("FAIL single_data got=%h exp=a5", acc_q[0]); end
    end
    checks++; if (vcyc - v0 != 1) begin errors++; $display("FAIL single_valid_cycles got=%0d exp=1", vcyc - v0); end
    checks++; if (fe_cnt != fe0 || ov_cnt != ov0) begin errors++; $display("FAIL single_no_err got fe=%0d ov=%0d exp 0 0", fe_cnt - fe0, ov_cnt - ov0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    int fe0;
    acc_q.delete();
    fe0 = fe_cnt;
    for (int f = 0; f < 13; f++) begin
      exp = (f < 12) ? 8'(f) : 8'h00;
      send_bits({8'h00, exp}, 8, 8);
      close_cs();
      wait_clk(10);
    end
    wait_clk(10);
    checks++; if (acc_q.size() != 13) begin errors++; $display("FAIL b2b_count got=%0d exp=13", acc_q.size()); end
    else begin
      for (int f = 0; f < 13; f++) begin
        exp = (f < 12) ? 8'(f) : 8'h00;
        checks++; if (acc_q[f] !== exp) begin errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", f, acc_q[f], exp); end
      end
    end
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL b2b_no_err got=%0d exp=0", fe_cnt - fe0); end
  endtask

  task automatic test_short_frame();
    int fe0;
    acc_q.delete();
    fe0 = fe_cnt;
    send_frame(16'h0015, 5, 8);
    checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL short_frame_err got=%0d exp=1", fe_cnt - fe0); end
    checks++; if (acc_q.size() != 0) begin errors++; $display("FAIL short_no_commit got=%0d exp=0", acc_q.size()); end
    send_frame(16'h003C, 8, 8);
    checks++; if (acc_q.size() != 1) begin errors++; $display("FAIL short_next_count got=%0d exp=1", acc_q.size()); end
    else begin
      checks++; if (acc_q[0] !== 8'h3C) begin errors++; $display("FAIL short_next_data got=%h exp=3c", acc_q[0]); end
    end
  endtask

  task automatic test_long_frame();
    int fe0, ov0;
    acc_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(16'h02F3, 10, 8);
    checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL long_frame_err got=%0d exp=1", fe_cnt - fe0); end
    checks++; if (acc_q.size() != 0 || rx_valid !== 1'b0) begin errors++; $display("FAIL long_no_commit got n=%0d vld=%b exp 0 0", acc_q.size(), rx_valid); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL long_data_held got=%h exp=3c", rx_data); end
    checks++; if (ov_cnt != ov0) begin errors++; $display("FAIL long_no_overrun got=%0d exp=0", ov_cnt - ov0); end
  endtask

  task automatic test_overrun();
    int ov0;
    acc_q.delete();
    rx_ready = 1'b0;
    send_frame(16'h0011, 8, 8);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin errors++; $display("FAIL ovr_first got vld=%b data=%h exp 1 11", rx_valid, rx_data); end
    ov0 = ov_cnt;
    send_frame(16'h0022, 8, 8);
    checks++; if (ov_cnt - ov0 != 1) begin errors++; $display("FAIL ovr_pulse got=%0d exp=1", ov_cnt - ov0); end
    checks++; if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_held got vld=%b data=%h exp 1 11", rx_valid, rx_data); end
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain_valid got=%b exp=0", rx_valid); end
    checks++; if (acc_q.size() != 1 || acc_q[acc_q.size()-1] !== 8'h11) begin errors++; $display("FAIL ovr_drain_data got n=%0d exp one 11", acc_q.size()); end

    // Commit landing in the same cycle as a handshake.
    send_frame(16'h0033, 8, 8);
    ov0 = ov_cnt;
    send_bits(16'h0044, 8, 8);
    close_cs();
    wait_clk(3);
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h44) begin errors++; $display("FAIL same_cycle_load got vld=%b data=%h exp 1 44", rx_valid, rx_data); end
    checks++; if (ov_cnt != ov0) begin errors++; $display("FAIL same_cycle_no_overrun got=%0d exp=0", ov_cnt - ov0); end
    checks++; if (acc_q.size() != 2 || acc_q[acc_q.size()-1] !== 8'h33) begin errors++; $display("FAIL same_cycle_accept got n=%0d exp 2 ending 33", acc_q.size()); end
    wait_clk(5);
    rx_ready = 1'b1;
    wait_clk(2);
    checks++; if (acc_q.size() != 3 || acc_q[acc_q.size()-1] !== 8'h44) begin errors++; $display("FAIL same_cycle_drain got n=%0d exp 3 ending 44", acc_q.size()); end
  endtask

  task automatic test_reset_mid();
    int fe0;
    rx_ready = 1'b1;
    send_bits(16'h000F, 4, 8);
    reset = 1'b1;
    #2;
    checks++; if (rx_data !== 8'h00 || rx_valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0)
      begin errors++; $display("FAIL mid_reset_outputs got data=%h vld=%b busy=%b fe=%b ov=%b exp all 0", rx_data, rx_valid, busy, frame_err, overrun); end
    spi_cs_n = 1'b1; spi_sclk = 1'b0;
    wait_clk(5);
    reset = 1'b0;
    acc_q.delete();
    fe0 = fe_cnt;
    wait_clk(20);
    checks++; if (acc_q.size() != 0 || fe_cnt != fe0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset_no_commit got n=%0d fe=%0d busy=%b exp 0 0 0", acc_q.size(), fe_cnt - fe0, busy); end
    send_frame(16'h007E, 8, 8);
    checks++; if (acc_q.size() != 1 || rx_data !== 8'h7E) begin errors++; $display("FAIL mid_reset_next got n=%0d data=%h exp 1 7e", acc_q.size(), rx_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_short_frame();
    test_long_frame();
    test_overrun();
    test_reset_mid();
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL err_overrun_exclusive got=%0d exp=0", both_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
